layer_input_sequencer: RTL
==========================

Name: layer_input_sequencer

Overview:
- Sits between two fully connected layers.
- Captures the parallel per-neuron outputs of layer L, one value plus one outvalid pulse per neuron.
- Replays them to every neuron of layer L+1 as a single contiguous serial burst on a shared myinput/myinputValid bus.
- Blocks the next burst until layer L+1 reports completion, so a neuron's read-address counter and end-of-burst detection always see exactly NUM_IN back-to-back valid samples.

Parameters:
- NUM_IN, 30, number of neurons in layer L = samples per burst (must equal numWeight of layer L+1 neurons)
- DATA_WIDTH, 16, width of each neuron output sample

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  NUM_IN*DATA_WIDTH  packed layer-L outputs; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  NUM_IN  per-lane outvalid pulse from layer-L neuron i
- layer_done  input  1  outvalid of any one layer-L+1 neuron (all finish together)
- out_data  output  DATA_WIDTH  serial sample to layer-L+1 myinput
- out_valid  output  1  to layer-L+1 myinputValid
- out_index  output  $clog2(NUM_IN)  index of sample currently on out_data
- busy  output  1  high in STREAM or WAIT_DONE
- overrun  output  1  sticky error flag

Behaviour:
- Reset (sync, rst=1 at an edge): state=COLLECT; got[] all 0; idx=0; out_valid=0; out_data=0; out_index=0; busy=0; overrun=0. Reset mid-burst aborts immediately: out_valid=0 from the next cycle, buffer contents are don't-care.
- Storage: buf[NUM_IN] of DATA_WIDTH registers, plus got[NUM_IN] flags.
- COLLECT:
  - Each cycle, for every lane with in_valid[i]=1: buf[i] <= lane i, got[i] <= 1. Lanes may pulse in any order and in any combination of cycles, including all in one cycle.
  - If in_valid[i]=1 while got[i] is already 1: buf[i] is overwritten with the new value and overrun <= 1.
  - Leave COLLECT when (got | in_valid) is all ones at an edge, i.e. the last missing lane is captured on that edge. That edge: state <= STREAM, got <= 0, idx <= 0.
- STREAM:
  - out_valid=1, out_data=buf[idx], out_index=idx; idx increments every cycle.
  - No stall: exactly NUM_IN consecutive valid cycles.
  - At idx=NUM_IN-1: state <= WAIT_DONE, idx <= 0.
- WAIT_DONE: out_valid=0, out_data holds its last value. A layer_done=1 at an edge moves state to COLLECT.
- busy = (state != COLLECT).
- layer_done while in COLLECT or STREAM: ignored.
- in_valid while in STREAM or WAIT_DONE: sample dropped, got[] unchanged, overrun <= 1.
- overrun is cleared only by rst.
- Latency: the first out_valid cycle is the cycle immediately after the edge that captured the last lane.
- Timing: out_data, out_valid and out_index are registered outputs; no combinational path from inputs to outputs.
- Data: samples pass through unmodified, with no sign or width change.

Test Plan:
- NUM_IN=4: pulse lanes 0..3 in 4 separate cycles with values 0x0010, 0x0020, 0x0030, 0x0040 → 4 consecutive out_valid cycles starting the cycle after lane 3 is captured; out_data 0x0010, 0x0020, 0x0030, 0x0040; out_index 0..3; then busy=1, out_valid=0.
- All 4 lanes pulse in the same cycle with values 0xFFFF, 0x8000, 0x7FFF, 0x0001 → burst starts next cycle with exactly those values in lane order; overrun stays 0.
- In WAIT_DONE, hold layer_done=0 for 10 cycles → no out_valid, busy=1. Then pulse layer_done → busy=0 next cycle; a second full set of lanes produces a second 4-cycle burst.
- In COLLECT, lane 2 pulses 0x1111 then 0x2222 before the other lanes arrive → overrun=1 and the burst carries 0x2222 at index 2. A lane pulse during STREAM → overrun=1 and the burst data is unchanged.
- Assert rst at the 2nd STREAM cycle → out_valid=0 and busy=0 next cycle, overrun=0, got cleared; a fresh capture streams correctly.
- layer_done pulsed during COLLECT and during STREAM → no state change; the burst length is still 4.

Source files
------------

// File: rtl/layer_input_sequencer.sv
// Collects one output per layer-L neuron, then replays all of them as a single
// gap-free serial burst to layer L+1 and waits for layer L+1 to finish.
module layer_input_sequencer #(
  parameter int NUM_IN     = 30,
  parameter int DATA_WIDTH = 16,
  localparam int IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic                         layer_done,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  output logic [IDX_W-1:0]             out_index,
  output logic                         busy,
  output logic                         overrun
);

  // Handshake: out_valid has no ready. Layer L+1 must take a sample on every
  // cycle out_valid is high; a burst is always NUM_IN consecutive valid cycles.
  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  state_t                  state;
  logic [NUM_IN-1:0]       got;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [DATA_WIDTH-1:0]   sample_buf [NUM_IN];
  logic                    all_in;

  assign idx_next  = idx + IDX_W'(1);
  assign all_in    = &(got | in_valid);
  assign out_index = idx;

  // Lane capture only happens while collecting; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state == COLLECT) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_valid[i]) sample_buf[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      got       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (|(got & in_valid)) overrun <= 1'b1;
          if (all_in) begin
            state     <= STREAM;
            busy      <= 1'b1;
            got       <= '0;
            idx       <= '0;
            out_valid <= 1'b1;
            // Lane 0 may be arriving on this very edge, so bypass the buffer.
            out_data  <= in_valid[0] ? in_data[DATA_WIDTH-1:0] : sample_buf[0];
          end else begin
            got <= got | in_valid;
          end
        end
        STREAM: begin
          if (|in_valid) overrun <= 1'b1;
          if (idx == LAST_IDX) begin
            state     <= WAIT_DONE;
            idx       <= '0;
            out_valid <= 1'b0;
          end else begin
            idx      <= idx_next;
            out_data <= sample_buf[idx_next];
          end
        end
        WAIT_DONE: begin
          if (|in_valid) overrun <= 1'b1;
          if (layer_done) begin
            state <= COLLECT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule
